// File: rtl/mpc_dot_pkg.sv
// Shared widths, FSM state and tag types for the MPC dot-product accumulator.
// Optional feature macro: MPC_DOT_ACC_SAT_EN (saturating accumulate/output).
package mpc_dot_pkg;

    localparam int P_W     = 31;  // multiplier product width
    localparam int ACC_W   = 40;  // accumulator width, headroom for 512 full-scale terms
    localparam int OUT_W   = 21;  // solver word width
    localparam int FRAC_SH = 9;   // fraction bits of the b operand removed from the sum
    localparam int MUL_LAT = 4;   // multiplier latency in ce-qualified cycles

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Tags travelling alongside the operand pair through the multiplier.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    // Sign-extend a product to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_p(input logic signed [P_W-1:0] v);
        return {{(ACC_W-P_W){v[P_W-1]}}, v};
    endfunction

endpackage

// File: rtl/mpc_round_sat.sv
// Round-half-up, rescale and clip an accumulator sum to the solver word.
// MPC_DOT_ACC_SAT_EN defined: clip to the signed OUT_W range and report o_sat.
// Otherwise: keep the low OUT_W bits of the rounded value, o_sat tied low.
module mpc_round_sat
    import mpc_dot_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_sum,
    output logic signed [OUT_W-1:0] o_y,
    output logic                    o_sat
);

    localparam logic signed [ACC_W:0] ROUND_BIAS = (ACC_W+1)'(2**(FRAC_SH-1));

    // One extra bit so adding the bias can never wrap.
    logic signed [ACC_W:0] w_biased;
    assign w_biased = {i_sum[ACC_W-1], i_sum} + ROUND_BIAS;

`ifdef MPC_DOT_ACC_SAT_EN
    localparam logic signed [ACC_W:0] LIM_MAX = (ACC_W+1)'(2**(OUT_W-1)-1);
    localparam logic signed [ACC_W:0] LIM_MIN = ~LIM_MAX;  // -(2^(OUT_W-1))

    logic signed [ACC_W:0] w_shr;
    assign w_shr = w_biased >>> FRAC_SH;

    // Clip the rescaled value into the solver word range.
    always_comb begin
        o_y   = w_shr[OUT_W-1:0];
        o_sat = 1'b0;
        if (w_shr > LIM_MAX) begin
            o_y   = LIM_MAX[OUT_W-1:0];
            o_sat = 1'b1;
        end else if (w_shr < LIM_MIN) begin
            o_y   = LIM_MIN[OUT_W-1:0];
            o_sat = 1'b1;
        end
    end
`else
    // Wrapping build: only the low OUT_W bits of the rescaled value survive.
    assign o_y   = OUT_W'(w_biased >>> FRAC_SH);
    assign o_sat = 1'b0;
`endif

endmodule

// File: rtl/mpc_dot_acc.sv
// Accumulates multiplier products into row dot products and emits each row
// result rounded/rescaled to the solver word, with tags delayed to match p.
// Optional feature macro: MPC_DOT_ACC_SAT_EN (saturating accumulator, clipped
// output and active sat_flag); without it the accumulator and output wrap.
module mpc_dot_acc
    import mpc_dot_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic signed [P_W-1:0]   p,
    output logic signed [OUT_W-1:0] y,
    output logic                    y_valid,
    output logic                    sat_flag,
    output logic                    seq_err,
    output logic                    busy
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_add;
    logic signed [ACC_W-1:0] w_p_ext;
    logic signed [OUT_W-1:0] r_y;
    logic signed [OUT_W-1:0] w_rs_y;
    logic                    r_y_valid;
    logic                    r_seq_err;
    logic                    w_result;
    logic                    w_seq_set;
    logic                    w_rs_sat;
    logic [MUL_LAT-1:0]      w_tag_v;
    tag_t                    w_d;

    // ------------------------------------------------------------------
    // Tag delay line: stage MUL_LAT-1 lines up with the product on p.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < MUL_LAT; gi++) begin : g_dly
            tag_t r_stage;
            tag_t w_stage_in;
            if (gi == 0) begin : g_src
                assign w_stage_in = '{valid: in_valid,
                                      first: in_valid & in_first,
                                      last:  in_valid & in_last};
            end else begin : g_src
                assign w_stage_in = g_dly[gi-1].r_stage;
            end
            // Advance the tag one stage per ce-cycle.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_stage <= '0;
                end else if (ce) begin
                    r_stage <= w_stage_in;
                end
            end
            assign w_tag_v[gi] = r_stage.valid;
        end
    endgenerate

    assign w_d     = g_dly[MUL_LAT-1].r_stage;
    assign w_p_ext = sext_p(p);

    // ------------------------------------------------------------------
    // Accumulator adder (saturating or wrapping).
    // ------------------------------------------------------------------
`ifdef MPC_DOT_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] w_sum_wide;
    logic                  w_add_ovf;
    logic                  r_row_sat;
    logic                  w_row_sat_next;
    logic                  r_sat_flag;

    assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_p_ext[ACC_W-1], w_p_ext};
    assign w_add_ovf  = (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]);
    assign w_add      = !w_add_ovf ? w_sum_wide[ACC_W-1:0]
                                   : (w_sum_wide[ACC_W] ? ACC_MIN : ACC_MAX);
`else
    assign w_add = r_acc + w_p_ext;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (ce) begin
            r_state <= w_state_next;
        end
    end

    // Next state, accumulator update and result strobe from the aligned tags.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_result     = 1'b0;
        w_seq_set    = 1'b0;
`ifdef MPC_DOT_ACC_SAT_EN
        w_row_sat_next = r_row_sat;
`endif
        if (w_d.valid) begin
            if (w_d.first) begin
                // A new row always restarts; an open row is abandoned.
                w_acc_next = w_p_ext;
`ifdef MPC_DOT_ACC_SAT_EN
                w_row_sat_next = 1'b0;
`endif
                if (r_state == ACC) begin
                    w_seq_set = 1'b1;
                end
                if (w_d.last) begin
                    w_result     = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = ACC;
                end
            end else if (r_state == ACC) begin
                w_acc_next = w_add;
`ifdef MPC_DOT_ACC_SAT_EN
                w_row_sat_next = r_row_sat | w_add_ovf;
`endif
                if (w_d.last) begin
                    w_result     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            // Terms outside an open row are dropped.
        end
    end

    // Round the sum including the current term, so the result lands one cycle after d_last.
    mpc_round_sat u_round_sat (
        .i_sum (w_acc_next),
        .o_y   (w_rs_y),
        .o_sat (w_rs_sat)
    );

    // Accumulator, result and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_seq_err <= 1'b0;
        end else if (ce) begin
            r_acc     <= w_acc_next;
            r_y_valid <= w_result;
            r_seq_err <= r_seq_err | w_seq_set;
            if (w_result) begin
                r_y <= w_rs_y;
            end
        end
    end

`ifdef MPC_DOT_ACC_SAT_EN
    // Per-row clip tracking; flag covers accumulator or output clipping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_sat  <= 1'b0;
            r_sat_flag <= 1'b0;
        end else if (ce) begin
            r_row_sat <= w_row_sat_next;
            if (w_result) begin
                r_sat_flag <= w_rs_sat | w_row_sat_next;
            end
        end
    end
    assign sat_flag = r_sat_flag;
`else
    assign sat_flag = w_rs_sat;
`endif

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign seq_err = r_seq_err;
    assign busy    = (r_state == ACC) | (|w_tag_v);

endmodule

// File: tb/tb_mpc_dot_acc.sv
`timescale 1ns/1ps
module tb_mpc_dot_acc;

    localparam int P_W     = 31;
    localparam int ACC_W   = 40;
    localparam int OUT_W   = 21;
    localparam int FRAC_SH = 9;
    localparam int MUL_LAT = 4;

    localparam longint AMAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ACC_W-1));
    localparam longint YMAX = (longint'(1) <<< (OUT_W-1)) - 1;
    localparam longint YMIN = -(longint'(1) <<< (OUT_W-1));

    logic                    clk      = 1'b0;
    logic                    rst      = 1'b1;
    logic                    ce       = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_first = 1'b0;
    logic                    in_last  = 1'b0;
    logic signed [P_W-1:0]   op_p     = '0;
    logic signed [P_W-1:0]   mul_pipe [MUL_LAT];
    logic signed [P_W-1:0]   p;
    logic signed [OUT_W-1:0] y;
    logic                    y_valid;
    logic                    sat_flag;
    logic                    seq_err;
    logic                    busy;

    int     cyc    = 0;
    int     checks = 0;
    int     errors = 0;
    longint got_y[$];
    bit     got_sat[$];
    int     got_cyc[$];
    longint exp_y[$];
    bit     exp_sat[$];
    int     exp_cyc[$];
    longint rp[16];

    typedef struct {
        longint p;
        longint y;
        bit     s;
    } vec_t;
    vec_t tbl[10];

    mpc_dot_acc dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .in_valid (in_valid),
        .in_first (in_first),
        .in_last  (in_last),
        .p        (p),
        .y        (y),
        .y_valid  (y_valid),
        .sat_flag (sat_flag),
        .seq_err  (seq_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the pipelined multiplier: product emerges MUL_LAT ce-cycles later.
    always @(posedge clk) begin
        if (ce) begin
            mul_pipe[0] <= op_p;
            for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end
    assign p = mul_pipe[MUL_LAT-1];

    // Collect each result pulse once per ce-cycle it is presented.
    always @(negedge clk) begin
        if (rst && ce && y_valid) begin
            got_y.push_back(longint'(y));
            got_sat.push_back(sat_flag);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Row result from plain arithmetic on the terms rp[0..n-1].
    function automatic void model(input int n, output longint ey, output bit es);
        longint s;
        longint r;
        s  = 0;
        es = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = s + rp[i];
`ifdef MPC_DOT_ACC_SAT_EN
            if (s > AMAX) begin s = AMAX; es = 1'b1; end
            else if (s < AMIN) begin s = AMIN; es = 1'b1; end
`else
            s = (s <<< (64-ACC_W)) >>> (64-ACC_W);
`endif
        end
        r = (s + (longint'(1) <<< (FRAC_SH-1))) >>> FRAC_SH;
`ifdef MPC_DOT_ACC_SAT_EN
        if (r > YMAX) begin r = YMAX; es = 1'b1; end
        else if (r < YMIN) begin r = YMIN; es = 1'b1; end
`else
        r = (r <<< (64-OUT_W)) >>> (64-OUT_W);
`endif
        ey = r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic term(input bit f, input bit l, input longint pv);
        ce       = 1'b1;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        op_p     = P_W'(pv);
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_row(input int n, input int gapmax, output int last_cyc);
        last_cyc = 0;
        for (int i = 0; i < n; i++) begin
            if (gapmax > 0) begin
                ce = 1'b0;
                repeat ($urandom_range(0, gapmax)) tick();
            end
            if (i == n-1) last_cyc = cyc;
            term(i == 0, i == n-1, rp[i]);
        end
    endtask

    task automatic push_exp(input longint ey, input bit es, input int ec);
        exp_y.push_back(ey);
        exp_sat.push_back(es);
        exp_cyc.push_back(ec);
    endtask

    task automatic drain(input int gapmax);
        in_valid = 1'b0;
        for (int k = 0; k < MUL_LAT + 3; k++) begin
            if (gapmax > 0) begin
                ce = 1'b0;
                repeat ($urandom_range(0, gapmax)) tick();
            end
            ce = 1'b1;
            tick();
        end
    endtask

    task automatic compare(input string name);
        longint gy, ey;
        bit     gs, es;
        int     gc, ec;
        check({name, " count"}, got_y.size(), exp_y.size());
        while (got_y.size() > 0 && exp_y.size() > 0) begin
            gy = got_y.pop_front();  gs = got_sat.pop_front();  gc = got_cyc.pop_front();
            ey = exp_y.pop_front();  es = exp_sat.pop_front();  ec = exp_cyc.pop_front();
            $display("row %s: y=%0d (exp %0d) sat=%0d (exp %0d)", name, gy, ey, gs, es);
            check({name, " y"}, gy, ey);
            check({name, " sat_flag"}, longint'(gs), longint'(es));
            if (ec >= 0) check({name, " latency"}, gc, ec);
        end
        got_y.delete();  got_sat.delete();  got_cyc.delete();
        exp_y.delete();  exp_sat.delete();  exp_cyc.delete();
    endtask

    initial begin
        int     lc;
        int     n;
        int     g;
        longint ey;
        bit     es;
        logic [P_W-1:0] raw;

        tbl[0] = '{767, 1, 1'b0};
        tbl[1] = '{-256, 0, 1'b0};
        tbl[2] = '{-257, -1, 1'b0};
        tbl[3] = '{256, 1, 1'b0};
        tbl[4] = '{255, 0, 1'b0};
        tbl[5] = '{-768, -1, 1'b0};
        tbl[6] = '{536870144, 1048575, 1'b0};
`ifdef MPC_DOT_ACC_SAT_EN
        tbl[7] = '{536870656, 1048575, 1'b1};
        tbl[8] = '{1073741823, 1048575, 1'b1};
        tbl[9] = '{-1073741824, -1048576, 1'b1};
`else
        tbl[7] = '{536870656, -1048576, 1'b0};
        tbl[8] = '{1073741823, 0, 1'b0};
        tbl[9] = '{-1073741824, 0, 1'b0};
`endif

        // Power-on reset state.
        #2 rst = 1'b0;
        #1;
        check("reset y", y, 0);
        check("reset y_valid", y_valid, 0);
        check("reset sat_flag", sat_flag, 0);
        check("reset seq_err", seq_err, 0);
        check("reset busy", busy, 0);
        #9 rst = 1'b1;
        tick();

        // Three-term row: 512 + 1024 - 512 = 1024 -> 2.
        rp[0] = 512; rp[1] = 1024; rp[2] = -512;
        send_row(3, 0, lc);
        push_exp(2, 1'b0, lc + MUL_LAT + 1);
        drain(0);
        compare("three-term");
        check("busy idle after row", busy, 0);

        // Single-term rows from the vector table.
        for (int i = 0; i < 10; i++) begin
            rp[0] = tbl[i].p;
            send_row(1, 0, lc);
            if (i == 0) check("busy with tags in flight", busy, 1);
            push_exp(tbl[i].y, tbl[i].s, lc + MUL_LAT + 1);
            drain(0);
            compare($sformatf("one-term p=%0d", tbl[i].p));
        end

        // Four full-scale positive terms.
        for (int i = 0; i < 4; i++) rp[i] = 1073741823;
        send_row(4, 0, lc);
`ifdef MPC_DOT_ACC_SAT_EN
        push_exp(1048575, 1'b1, lc + MUL_LAT + 1);
`else
        push_exp(0, 1'b0, lc + MUL_LAT + 1);
`endif
        drain(0);
        compare("overflow 4x max");

        // Same five-term row without and with clock-enable gaps.
        rp[0] = 300000; rp[1] = -12345; rp[2] = 777777; rp[3] = 4096; rp[4] = -99;
        send_row(5, 0, lc);
        push_exp(2089, 1'b0, lc + MUL_LAT + 1);
        drain(0);
        compare("five-term ce=1");
        send_row(5, 3, lc);
        push_exp(2089, 1'b0, -1);
        drain(3);
        compare("five-term ce gaps");

        // Sequence error: the second first discards the open row.
        term(1'b1, 1'b0, 5120);
        term(1'b0, 1'b0, 512);
        term(1'b1, 1'b0, 1024);
        lc = cyc;
        term(1'b0, 1'b1, 2048);
        check("seq_err before restart seen", seq_err, 0);
        push_exp(6, 1'b0, lc + MUL_LAT + 1);
        drain(0);
        compare("restarted row");
        check("seq_err set", seq_err, 1);

        // Back-to-back rows with no idle cycle.
        rp[0] = 512; rp[1] = 512;
        send_row(2, 0, lc);
        push_exp(2, 1'b0, lc + MUL_LAT + 1);
        rp[0] = -1024; rp[1] = -512;
        send_row(2, 0, lc);
        push_exp(-3, 1'b0, lc + MUL_LAT + 1);
        drain(0);
        compare("back-to-back");
        check("seq_err sticky", seq_err, 1);

        // Reset in the middle of an open row.
        term(1'b1, 1'b0, 1000);
        term(1'b0, 1'b0, 2000);
        ce = 1'b1;
        repeat (MUL_LAT + 1) tick();
        check("busy with row open", busy, 1);
        #3 rst = 1'b0;
        #2;
        check("mid-row reset y", y, 0);
        check("mid-row reset y_valid", y_valid, 0);
        check("mid-row reset sat_flag", sat_flag, 0);
        check("mid-row reset seq_err", seq_err, 0);
        check("mid-row reset busy", busy, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        term(1'b0, 1'b1, 5000);  // stray last with no open row: dropped
        drain(0);
        compare("after reset stray last");
        check("y after stray last", y, 0);
        rp[0] = 512; rp[1] = 512; rp[2] = 512;
        send_row(3, 0, lc);
        push_exp(3, 1'b0, lc + MUL_LAT + 1);
        drain(0);
        compare("clean row after reset");
        check("seq_err after reset", seq_err, 0);

        // Randomized rows against the arithmetic model.
        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(1, 8);
            g = ($urandom_range(0, 3) == 0) ? 2 : 0;
            for (int i = 0; i < n; i++) begin
                raw = P_W'($urandom);
                if ($urandom_range(0, 1) == 1) rp[i] = longint'($signed(raw));
                else                           rp[i] = longint'($signed(raw)) >>> 18;
            end
            model(n, ey, es);
            send_row(n, g, lc);
            push_exp(ey, es, -1);
            if ($urandom_range(0, 2) == 0) drain(g);
        end
        drain(0);
        compare("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
